apb_regfile_slave: RTL and testbench

APB completer that sits directly downstream of the AHB-to-APB bridge and is driven by one of the bridge's four PSEL lines. It holds a small word-addressed register file. It supports byte-strobed writes, a programmable number of wait states, a read-only ID register at offset 0, and PSLVERR error signalling. It lets the bridge's PREADY/PRDATA handshake be exercised against a real, stateful slave.

---
 rtl/apb_regfile_slave.sv | 176 +++++++++++++++++
 tb/tb_apb_regfile_slave.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_regfile_slave.sv
// APB completer holding a byte-strobed register file, with a programmable
// number of wait states, a read-only ID word at offset 0 and PSLVERR reporting.

module apb_regfile_byte_lane (
    input  logic       strb,
    input  logic [7:0] old_byte,
    input  logic [7:0] new_byte,
    output logic [7:0] merged
);
    assign merged = strb ? new_byte : old_byte;
endmodule

module apb_regfile_slave #(
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic        HCLK,
    input  logic        HRSTn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic [31:0] PADDR,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    input  logic [3:0]  PSTRB,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;

    localparam int         IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [6:0] NUM_REGS_L = 7'(NUM_REGS);
    localparam logic [3:0] WAIT_INIT  = 4'(WAIT_STATES);

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             write_q, write_d;
    logic             err_q, err_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       strb_q, strb_d;
    logic [31:0]      prdata_q, prdata_d;
    logic             pready_q, pready_d;
    logic             pslverr_q, pslverr_d;
    logic [31:0]      regs_q [NUM_REGS];
    logic [31:0]      regs_d [NUM_REGS];

    logic [5:0]       bus_idx;
    logic             setup, setup_err;
    logic             go_ready;
    logic [IDX_W-1:0] src_idx;
    logic             src_err, src_write;
    logic [31:0]      cur_word, merged;
    logic             unused_ok;

    // Upper address bits are decoded by the bridge.
    assign unused_ok = ^PADDR[31:8];

    assign bus_idx   = PADDR[7:2];
    assign setup     = PSEL && !PENABLE;
    assign setup_err = (PADDR[1:0] != 2'b00) ||
                       ({1'b0, bus_idx} >= NUM_REGS_L) ||
                       (PWRITE && (bus_idx == 6'd0));

    // With zero wait states the response is built straight from the live setup
    // phase; otherwise it comes from the values captured at setup.
    assign src_idx   = (state_q == S_IDLE) ? PADDR[IDX_W+1:2] : idx_q;
    assign src_err   = (state_q == S_IDLE) ? setup_err : err_q;
    assign src_write = (state_q == S_IDLE) ? PWRITE : write_q;

    assign cur_word  = regs_q[idx_q];

    for (genvar g = 0; g < 4; g++) begin : g_lane
        apb_regfile_byte_lane u_lane (
            .strb     (strb_q[g]),
            .old_byte (cur_word[8*g +: 8]),
            .new_byte (wdata_q[8*g +: 8]),
            .merged   (merged[8*g +: 8])
        );
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        write_d   = write_q;
        err_d     = err_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        regs_d    = regs_q;
        go_ready  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (setup) begin
                    idx_d   = PADDR[IDX_W+1:2];
                    write_d = PWRITE;
                    err_d   = setup_err;
                    wdata_d = PWDATA;
                    strb_d  = PSTRB;
                    cnt_d   = WAIT_INIT;
                    if (WAIT_STATES == 0) begin
                        state_d  = S_READY;
                        go_ready = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!PSEL) begin
                    state_d = S_IDLE;
                end else if (cnt_q <= 4'd1) begin
                    state_d  = S_READY;
                    go_ready = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_READY: begin
                state_d = S_IDLE;
                if (write_q && !err_q) begin
                    regs_d[idx_q] = merged;
                end
            end
            default: state_d = S_IDLE;
        endcase

        pready_d  = go_ready;
        pslverr_d = go_ready && src_err;
        prdata_d  = '0;
        if (go_ready && !src_err && !src_write) begin
            prdata_d = (src_idx == '0) ? ID_VALUE : regs_q[src_idx];
        end
    end

    always_ff @(posedge HCLK or negedge HRSTn) begin
        if (!HRSTn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            err_q     <= err_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Scoreboard bench for apb_regfile_slave: bus 0 uses two wait states, bus 1 none.

module tb_apb_regfile_slave;
    logic        HCLK = 1'b0;
    logic        HRSTn;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [31:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [3:0]  pstrb   [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sbq0[$];
    exp_t        sbq1[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    apb_regfile_slave #(.NUM_REGS(16), .WAIT_STATES(2), .ID_VALUE(32'hA9B0_0001)) u_dut0 (
        .HCLK(HCLK), .HRSTn(HRSTn), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PADDR(paddr[0]), .PWRITE(pwrite[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
    );

    apb_regfile_slave #(.NUM_REGS(16), .WAIT_STATES(0), .ID_VALUE(32'hA9B0_0001)) u_dut1 (
        .HCLK(HCLK), .HRSTn(HRSTn), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PADDR(paddr[1]), .PWRITE(pwrite[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every PREADY pulse must match the oldest expectation for its bus.
    always @(negedge HCLK) begin
        exp_t e;
        bit   got;
        for (int w = 0; w < 2; w++) begin
            if (pready[w] === 1'b1) begin
                got = 1'b0;
                if (w == 0 && sbq0.size() != 0) begin e = sbq0.pop_front(); got = 1'b1; end
                if (w == 1 && sbq1.size() != 0) begin e = sbq1.pop_front(); got = 1'b1; end
                if (!got) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pready bus%0d: got PREADY=1 at cycle %0d expected no transfer", w, cyc);
                end else begin
                    check(w == 0 ? "prdata_bus0" : "prdata_bus1", prdata[w], e.data);
                    check(w == 0 ? "pslverr_bus0" : "pslverr_bus1", {31'b0, pslverr[w]}, {31'b0, e.err});
                    check(w == 0 ? "pready_cycle_bus0" : "pready_cycle_bus1", cyc, e.cyc);
                end
            end else begin
                check(w == 0 ? "idle_prdata_bus0" : "idle_prdata_bus1", prdata[w], 32'h0);
                check(w == 0 ? "idle_pslverr_bus0" : "idle_pslverr_bus1", {31'b0, pslverr[w]}, 32'h0);
            end
        end
    end

    // Called at posedge+1; leaves the bus idle at posedge+1 after the READY cycle,
    // so a following call starts back-to-back with no gap.
    task automatic xfer(input int w, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic [31:0] edata, input logic eerr);
        exp_t e;
        int   n;
        int   ws;
        ws = (w == 0) ? 2 : 0;
        psel[w] = 1'b1; penable[w] = 1'b0; pwrite[w] = wr;
        paddr[w] = addr; pwdata[w] = wdata; pstrb[w] = strb;
        e.data = edata; e.err = eerr; e.cyc = cyc + 1 + ws;
        if (w == 0) sbq0.push_back(e); else sbq1.push_back(e);
        @(posedge HCLK); #1;
        // Bus wiggles after setup must not affect the transfer.
        penable[w] = 1'b1; paddr[w] = addr ^ 32'h4; pwdata[w] = ~wdata; pstrb[w] = ~strb;
        n = 0;
        while (pready[w] !== 1'b1 && n < 20) begin @(negedge HCLK); n++; end
        if (pready[w] !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL pready_timeout bus%0d addr %h: got no PREADY expected one within 20 cycles", w, addr);
        end
        @(posedge HCLK); #1;
        psel[w] = 1'b0; penable[w] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        HRSTn = 1'b1;
        for (int w = 0; w < 2; w++) begin
            psel[w] = 0; penable[w] = 0; pwrite[w] = 0; paddr[w] = 0; pwdata[w] = 0; pstrb[w] = 0;
        end
        #2 HRSTn = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        for (int w = 0; w < 2; w++) begin
            check("reset_pready", {31'b0, pready[w]}, 32'h0);
            check("reset_prdata", prdata[w], 32'h0);
            check("reset_pslverr", {31'b0, pslverr[w]}, 32'h0);
        end
        HRSTn = 1'b1;
        idle(1);

        // Write then read
        xfer(0, 1, 32'h08, 32'h1234_5678, 4'hF, 32'h0, 0);
        xfer(0, 0, 32'h08, 32'h0, 4'h0, 32'h1234_5678, 0);
        idle(1);

        // Byte strobes and the no-op strobe
        xfer(0, 1, 32'h0C, 32'hFFFF_FFFF, 4'hF, 32'h0, 0);
        xfer(0, 1, 32'h0C, 32'h0000_00AB, 4'b0001, 32'h0, 0);
        xfer(0, 0, 32'h0C, 32'h0, 4'h0, 32'hFFFF_FFAB, 0);
        xfer(0, 1, 32'h0C, 32'h1122_3344, 4'h0, 32'h0, 0);
        xfer(0, 0, 32'h0C, 32'h0, 4'h0, 32'hFFFF_FFAB, 0);
        xfer(0, 1, 32'h0C, 32'h5566_7788, 4'b1010, 32'h0, 0);
        xfer(0, 0, 32'h0C, 32'h0, 4'h0, 32'h55FF_77AB, 0);

        // ID register is read-only
        xfer(0, 0, 32'h00, 32'h0, 4'h0, 32'hA9B0_0001, 0);
        xfer(0, 1, 32'h00, 32'hDEAD_BEEF, 4'hF, 32'h0, 1);
        xfer(0, 0, 32'h00, 32'h0, 4'h0, 32'hA9B0_0001, 0);

        // Error cases leave state untouched
        xfer(0, 0, 32'h40, 32'h0, 4'h0, 32'h0, 1);
        xfer(0, 1, 32'h06, 32'h5555_5555, 4'hF, 32'h0, 1);
        xfer(0, 0, 32'h04, 32'h0, 4'h0, 32'h0, 0);
        xfer(0, 0, 32'h0A, 32'h0, 4'h0, 32'h0, 1);
        xfer(0, 0, 32'h3C, 32'h0, 4'h0, 32'h0, 0);
        xfer(0, 0, 32'h08, 32'h0, 4'h0, 32'h1234_5678, 0);
        idle(2);

        // Back-to-back reads
        xfer(0, 0, 32'h08, 32'h0, 4'h0, 32'h1234_5678, 0);
        xfer(0, 0, 32'h0C, 32'h0, 4'h0, 32'h55FF_77AB, 0);
        idle(1);

        // Abort: PSEL drops during the wait phase
        psel[0] = 1; penable[0] = 0; pwrite[0] = 1; paddr[0] = 32'h08; pwdata[0] = 32'hBAD0_BAD0; pstrb[0] = 4'hF;
        @(posedge HCLK); #1;
        penable[0] = 1;
        @(posedge HCLK); #1;
        psel[0] = 0; penable[0] = 0;
        idle(4);
        xfer(0, 0, 32'h08, 32'h0, 4'h0, 32'h1234_5678, 0);

        // Zero wait states
        xfer(1, 1, 32'h08, 32'hCAFE_0001, 4'hF, 32'h0, 0);
        xfer(1, 0, 32'h08, 32'h0, 4'h0, 32'hCAFE_0001, 0);
        xfer(1, 0, 32'h00, 32'h0, 4'h0, 32'hA9B0_0001, 0);
        xfer(1, 0, 32'h40, 32'h0, 4'h0, 32'h0, 1);
        xfer(1, 1, 32'h00, 32'h1, 4'hF, 32'h0, 1);
        xfer(1, 1, 32'h3C, 32'h0BAD_F00D, 4'b1100, 32'h0, 0);
        xfer(1, 0, 32'h3C, 32'h0, 4'h0, 32'h0BAD_0000, 0);
        idle(1);

        // Reset asserted during the READY cycle of a write
        psel[0] = 1; penable[0] = 0; pwrite[0] = 1; paddr[0] = 32'h14; pwdata[0] = 32'h0000_0077; pstrb[0] = 4'hF;
        e.data = 32'h0; e.err = 1'b0; e.cyc = cyc + 3;
        sbq0.push_back(e);
        @(posedge HCLK); #1;
        penable[0] = 1;
        n = 0;
        while (pready[0] !== 1'b1 && n < 20) begin @(negedge HCLK); n++; end
        if (pready[0] !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL rst_pready_timeout: got no PREADY expected one within 20 cycles");
        end
        #2 HRSTn = 1'b0;
        #1;
        check("rst_mid_pready", {31'b0, pready[0]}, 32'h0);
        check("rst_mid_prdata", prdata[0], 32'h0);
        check("rst_mid_pslverr", {31'b0, pslverr[0]}, 32'h0);
        psel[0] = 0; penable[0] = 0;
        @(posedge HCLK); #1;
        HRSTn = 1'b1;
        idle(1);
        xfer(0, 0, 32'h08, 32'h0, 4'h0, 32'h0, 0);
        xfer(0, 0, 32'h0C, 32'h0, 4'h0, 32'h0, 0);
        xfer(0, 0, 32'h14, 32'h0, 4'h0, 32'h0, 0);
        xfer(0, 0, 32'h00, 32'h0, 4'h0, 32'hA9B0_0001, 0);
        xfer(1, 0, 32'h08, 32'h0, 4'h0, 32'h0, 0);

        idle(6);
        check("sb_empty_bus0", sbq0.size(), 32'h0);
        check("sb_empty_bus1", sbq1.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
